// File: rtl/fpu_cast_arbiter.sv
// Two-requester arbiter/sequencer around a shared int-to-float cast datapath.
// Define FPU_CAST_ROUND_ROBIN_EN for round-robin ties; otherwise requester A has fixed priority.
module fpu_cast_arbiter (
  input  logic        clk,
  input  logic        clr,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_in,
  input  logic        a_signed,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_in,
  input  logic        b_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_id,
  output logic [31:0] out_data,
  output logic        busy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // readies depend combinationally on valid, and valid must not depend on ready.

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic        sgn_q, sgn_d;
  logic        tag_q, tag_d;
  logic [31:0] res_q, res_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        grant_a, grant_b;
`ifdef FPU_CAST_ROUND_ROBIN_EN
  logic        last_q, last_d;
`endif

  // Round-to-nearest-even conversion; magnitude is normalised so bit 31 is the hidden one.
  function automatic logic [31:0] cast_int_to_float(input logic [31:0] v, input logic sg);
    logic        s;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  p;
    logic        inc;
    logic [24:0] mant;
    logic [7:0]  e;
    logic [31:0] r;
    s   = sg & v[31];
    mag = s ? (~v + 32'd1) : v;
    p   = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) p = 5'(i);
    end
    norm = mag << (5'd31 - p);
    inc  = norm[7] & ((|norm[6:0]) | norm[8]);
    mant = {1'b0, norm[31:8]} + {24'd0, inc};
    e    = 8'd127 + {3'd0, p} + {7'd0, mant[24]};
    r    = {s, e, mant[24] ? 23'd0 : mant[22:0]};
    if (mag == 32'd0) r = '0;
    return r;
  endfunction

  always_comb begin
    grant_b = b_valid & ~a_valid;
`ifdef FPU_CAST_ROUND_ROBIN_EN
    if (a_valid & b_valid) grant_b = ~last_q;
`endif
    grant_a = a_valid & ~grant_b;
  end

  assign a_ready   = clr & (state_q == ST_IDLE) & grant_a;
  assign b_ready   = clr & (state_q == ST_IDLE) & grant_b;
  assign out_valid = out_valid_q;
  assign out_id    = tag_q;
  assign out_data  = res_q;
  assign busy      = busy_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    tag_d   = tag_q;
    res_d   = res_q;
`ifdef FPU_CAST_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (a_ready | b_ready) begin
          op_d    = grant_b ? b_in : a_in;
          sgn_d   = grant_b ? b_signed : a_signed;
          tag_d   = grant_b;
`ifdef FPU_CAST_ROUND_ROBIN_EN
          last_d  = grant_b;
`endif
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        res_d   = cast_int_to_float(op_q, sgn_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      sgn_q       <= 1'b0;
      tag_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FPU_CAST_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sgn_q       <= sgn_d;
      tag_q       <= tag_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef FPU_CAST_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: doc/fpu_cast_arbiter.md
# fpu_cast_arbiter

Arbiter and sequencer that shares one `cast_int_to_float` datapath between two requesters, for example the ALU issue path and the FPU microcode port. It accepts one conversion at a time through valid/ready handshakes and registers the operand and the result around the combinational cast. It then holds the tagged result until the consumer accepts it. It sits in the FPU between the register-file read stage and the writeback mux.

## Interface
Parameters:
- None. Operand and result width is fixed at 32 bits by the cast datapath.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `clr`  in  1  reset, synchronous, active-low
- `a_valid`  in  1  requester A has an operand
- `a_ready`  out  1  requester A operand accepted this cycle
- `a_in`  in  32  requester A integer operand
- `a_signed`  in  1  requester A: 1 = two's complement, 0 = unsigned
- `b_valid`  in  1  requester B has an operand
- `b_ready`  out  1  requester B operand accepted this cycle
- `b_in`  in  32  requester B integer operand
- `b_signed`  in  1  requester B signedness
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_id`  out  1  0 = result belongs to A, 1 = result belongs to B
- `out_data`  out  32  IEEE-754 single-precision result
- `busy`  out  1  high whenever state is not IDLE

## Operation
- State machine with three states.
- **IDLE**
  - `a_ready`/`b_ready` are combinational: high only for the granted requester, and only while in IDLE.
  - Grant rules:
    - Only A valid: grant A.
    - Only B valid: grant B.
    - Both valid: decided by the arbitration policy (see Configuration).
  - On handshake (`x_valid & x_ready`):
    - Capture `x_in` and `x_signed` into the operand register.
    - Capture the granted id into the tag register.
    - Go to CONVERT.
- **CONVERT**
  - The operand register drives the cast datapath.
  - The result is captured into the result register.
  - Go to DONE.
- **DONE**
  - `out_valid`=1, with `out_data` and `out_id` stable.
  - On `out_valid & out_ready`: go to IDLE.
  - Otherwise hold indefinitely; `out_data`/`out_id` must not change.
- No new operand is accepted outside IDLE, so both readies are 0 in CONVERT and DONE.
- A requester must hold `x_in`/`x_signed` stable while `x_valid`=1 and unaccepted. The arbiter never drops an asserted request.
- Results are bit-exact to the cast datapath:
  - Round to nearest even.
  - Zero gives +0.
  - Signed `0x80000000` gives `0xCF000000`.

## Timing
- Reset (`clr`=0 at a rising edge):
  - State goes to IDLE.
  - `out_valid`=0, `out_data`=0, `out_id`=0, `busy`=0.
  - Last-grant register goes to 1, so A wins the first tie.
  - While `clr` is low, `a_ready`=`b_ready`=0.
- Reset mid-operation (CONVERT or DONE) discards the in-flight conversion; no result is ever presented for it.
- Latency: an accept at edge N gives `out_valid`=1 in the cycle after edge N+1, i.e. 2 cycles from handshake to result.
- Minimum issue interval is 3 cycles (IDLE, CONVERT, DONE with immediate `out_ready`). The DONE→IDLE edge does not accept a new request; the earliest next accept is the following cycle.
- `out_ready` asserted while `out_valid`=0 has no effect.
- Simultaneous `a_valid` and `b_valid` in IDLE: exactly one ready is asserted, never both.

## Configuration
- `FPU_CAST_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. On a tie, grant the requester opposite the last-grant register.
  - The last-grant register updates on every accepted handshake.
- Not defined:
  - Fixed priority. A always wins ties; the last-grant register is not implemented.
  - B can starve while A stays valid.

## Test plan
- Reset then single request: A sends `0xFFFFFFFF` signed, `out_ready`=1 → `out_valid` 2 cycles after accept, `out_data`=`0xBF800000`, `out_id`=0, `busy` high for exactly 2 cycles.
- Backpressure: B sends `0xFFFFFFFF` unsigned with `out_ready`=0 for 5 cycles → `out_data` held at `0x4F800000`, `out_id`=1, `b_ready`/`a_ready` low throughout; release → IDLE next cycle.
- Tie arbitration: A and B both valid continuously with `0x00000001` and `0x7FFFFFFF` signed:
  - With `_EN`: grants alternate A,B,A,B with results `0x3F800000` and `0x4F000000`.
  - Without `_EN`: four consecutive A grants.
- Rounding and edge operands through B: `0x01000001` unsigned → `0x4B800000`; `0x80000000` signed → `0xCF000000`; `0` signed → `0x00000000`.
- Reset mid-operation: assert `clr`=0 during CONVERT → no `out_valid` ever for that operand; after release, the first tie grants A.
- Stability: change `a_in` while `a_valid`=1 and `a_ready`=0 (B in flight) → the value captured is the one present on the accept cycle; no spurious accept.
